// File: rtl/pcu_pkg.sv
// Shared types for the RV32I pipeline control unit: opcodes, ALU/writeback encodings,
// the per-stage control bundle and the all-zero BUBBLE.
package pcu_pkg;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    WB_PC4   = 3'd0,
    WB_PCIMM = 3'd1,
    WB_ALU   = 3'd2,
    WB_LOAD  = 3'd3,
    WB_IMM   = 3'd4
  } wb_sel_e;

  typedef struct packed {
    logic       reg_write;
    wb_sel_e    mem_to_reg;
    logic       mem_write;
    logic [2:0] mem_func3;
    logic       alu_src;
    alu_op_e    alu_ctrl;
    logic       is_branch;
    logic [2:0] br_func3;
    logic       is_jal;
    logic       is_jalr;
    logic       is_load;
    logic       illegal;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

  // alt selects SUB/SRA; callers decide when func7 is allowed to matter
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Signal bundle between the datapath (master) and the pipeline control unit (slave).
interface pipeline_control_unit_if #(
  parameter int XLEN_REGS  = 32,
  parameter int ALU_CTRL_W = 4
);
  localparam int REG_W = $clog2(XLEN_REGS);

  logic [6:0]            opcode;
  logic [2:0]            func3;
  logic                  func7;
  logic [REG_W-1:0]      rs1_id;
  logic [REG_W-1:0]      rs2_id;
  logic [REG_W-1:0]      rd_ex;
  logic                  zero;
  logic                  less;

  logic                  alu_src;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  pc_sel;
  logic                  pc_src_alu;
  logic                  mem_write;
  logic [2:0]            mem_func3;
  logic                  reg_write;
  logic [2:0]            mem_to_reg;
  logic                  stall;
  logic                  flush;
  logic                  illegal_ex;

  modport master (
    output opcode, func3, func7, rs1_id, rs2_id, rd_ex, zero, less,
    input  alu_src, alu_ctrl, pc_sel, pc_src_alu, mem_write, mem_func3,
           reg_write, mem_to_reg, stall, flush, illegal_ex
  );

  modport slave (
    input  opcode, func3, func7, rs1_id, rs2_id, rd_ex, zero, less,
    output alu_src, alu_ctrl, pc_sel, pc_src_alu, mem_write, mem_func3,
           reg_write, mem_to_reg, stall, flush, illegal_ex
  );
endinterface

// File: rtl/pcu_decoder.sv
// Combinational ID-stage decode: opcode/func3/func7 -> control bundle and source-register usage.
// Unknown opcodes yield BUBBLE with illegal set and claim no source registers.
module pcu_decoder
  import pcu_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   func3,
  input  logic         func7,
  output ctrl_bundle_t ctrl,
  output logic         uses_rs1,
  output logic         uses_rs2,
  output logic         illegal
);

  always_comb begin
    ctrl     = BUBBLE;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_IMM;
        ctrl.alu_src    = 1'b1;
        uses_rs1        = 1'b0;
      end
      OP_AUIPC: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_PCIMM;
        ctrl.alu_src    = 1'b1;
        uses_rs1        = 1'b0;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_PC4;
        ctrl.is_jal     = 1'b1;
        uses_rs1        = 1'b0;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_PC4;
        ctrl.alu_src    = 1'b1;
        ctrl.is_jalr    = 1'b1;
      end
      OP_BRANCH: begin
        // BEQ/BNE compare by subtraction, the rest by signed/unsigned set-less-than
        ctrl.is_branch = 1'b1;
        ctrl.br_func3  = func3;
        ctrl.alu_ctrl  = !func3[2] ? ALU_SUB : (func3[1] ? ALU_SLTU : ALU_SLT);
        uses_rs2       = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_LOAD;
        ctrl.alu_src    = 1'b1;
        ctrl.is_load    = 1'b1;
        ctrl.mem_func3  = func3;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_func3 = func3;
        uses_rs2       = 1'b1;
      end
      OP_IMM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_ALU;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_ctrl   = alu_from_f3(func3, func7 && (func3 == 3'd5));
      end
      OP_OP: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_ALU;
        ctrl.alu_ctrl   = alu_from_f3(func3, func7);
        uses_rs2        = 1'b1;
      end
      default: begin
        illegal  = 1'b1;
        uses_rs1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Carries the decoded control bundle through ID/EX, EX/MEM and MEM/WB and drives each stage's controls.
// Also raises load-use stalls and branch/jump flushes; a redirect always overrides a stall.
module pipeline_control_unit
  import pcu_pkg::*;
#(
  parameter int XLEN_REGS  = 32,
  parameter int ALU_CTRL_W = 4
) (
  input logic                    clk,
  input logic                    reset,
  pipeline_control_unit_if.slave bus
);

  localparam int REG_W = $clog2(XLEN_REGS);

  ctrl_bundle_t     dec_ctrl;
  ctrl_bundle_t     id_bundle;
  logic             uses_rs1;
  logic             uses_rs2;
  logic             dec_illegal;
  logic [REG_W-1:0] rd_ex;

  ctrl_bundle_t ex_d, ex_q;
  ctrl_bundle_t mem_d, mem_q;
  ctrl_bundle_t wb_d, wb_q;

  logic ex_taken;
  logic redirect;
  logic load_use;

  pcu_decoder u_decoder (
    .opcode   (bus.opcode),
    .func3    (bus.func3),
    .func7    (bus.func7),
    .ctrl     (dec_ctrl),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .illegal  (dec_illegal)
  );

  assign rd_ex = bus.rd_ex;

  always_comb begin
    id_bundle         = dec_ctrl;
    id_bundle.illegal = dec_illegal;
  end

  always_comb begin
    ex_taken = 1'b0;
    if (ex_q.is_branch) begin
      case (ex_q.br_func3)
        3'b000:  ex_taken = bus.zero;
        3'b001:  ex_taken = !bus.zero;
        3'b100,
        3'b110:  ex_taken = bus.less;
        3'b101,
        3'b111:  ex_taken = !bus.less;
        default: ex_taken = 1'b0;
      endcase
    end
  end

  assign redirect = ex_taken || ex_q.is_jal || ex_q.is_jalr;

  // x0 is hardwired, so a load targeting it never creates a dependency
  assign load_use = ex_q.is_load && (rd_ex != '0) &&
                    ((uses_rs1 && (rd_ex == bus.rs1_id)) ||
                     (uses_rs2 && (rd_ex == bus.rs2_id)));

  always_comb begin
    ex_d  = id_bundle;
    mem_d = ex_q;
    wb_d  = mem_q;
    if (redirect || load_use) begin
      ex_d = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign bus.alu_src    = ex_q.alu_src;
  assign bus.alu_ctrl   = ALU_CTRL_W'(ex_q.alu_ctrl);
  assign bus.pc_sel     = redirect;
  assign bus.pc_src_alu = ex_q.is_jalr;
  assign bus.illegal_ex = ex_q.illegal;
  assign bus.mem_write  = mem_q.mem_write;
  assign bus.mem_func3  = mem_q.mem_func3;
  assign bus.reg_write  = wb_q.reg_write;
  assign bus.mem_to_reg = wb_q.mem_to_reg;
  assign bus.stall      = load_use && !redirect;
  assign bus.flush      = redirect;

  // Only the writeback fields of the last stage drive ports
  logic unused_wb_bits;
  assign unused_wb_bits = ^{wb_q.mem_write, wb_q.mem_func3, wb_q.alu_src, wb_q.alu_ctrl,
                            wb_q.is_branch, wb_q.br_func3, wb_q.is_jal, wb_q.is_jalr,
                            wb_q.is_load, wb_q.illegal};

endmodule
